multi_cycle_sequencer: RTL

- Sequencing controller for the multi-cycle CPU datapath. Holds the instruction state register and steps it IF→ID→EXE→MEM→WB per opcode.
- Stalls on memory wait-states and drives the per-state write enables, PC source select and memory strobes.
- Latches halt and illegal-opcode conditions and keeps cycle and retired-instruction counters.
- Sits between the IR opcode field, ALU flags, the unified memory port and the PC, IR and register-file write enables.

---
 rtl/cpu_ctrl_pkg.sv | 44 ++++
 rtl/ctrl_next_state.sv | 62 ++++++
 rtl/multi_cycle_sequencer.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multi-cycle CPU control path.
// Holds the sequencer state encodings, the opcode field constants and a
// helper that says whether an opcode is part of the defined instruction set.
// The ALU/decoder imports the same package, so these values must not drift.
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IF   = 3'b000,
    ST_ID   = 3'b001,
    ST_EXE  = 3'b010,
    ST_WB   = 3'b011,
    ST_MEM  = 3'b100,
    ST_HALT = 3'b101
  } state_t;

  localparam logic [5:0] OP_ADD  = 6'b000000;
  localparam logic [5:0] OP_SUB  = 6'b000001;
  localparam logic [5:0] OP_ADDI = 6'b000010;
  localparam logic [5:0] OP_OR   = 6'b010000;
  localparam logic [5:0] OP_AND  = 6'b010001;
  localparam logic [5:0] OP_ORI  = 6'b010010;
  localparam logic [5:0] OP_SLL  = 6'b011000;
  localparam logic [5:0] OP_SLT  = 6'b100110;
  localparam logic [5:0] OP_SLTI = 6'b100111;
  localparam logic [5:0] OP_SW   = 6'b110000;
  localparam logic [5:0] OP_LW   = 6'b110001;
  localparam logic [5:0] OP_BEQ  = 6'b110100;
  localparam logic [5:0] OP_BNE  = 6'b110101;
  localparam logic [5:0] OP_BGTZ = 6'b110110;
  localparam logic [5:0] OP_J    = 6'b111000;
  localparam logic [5:0] OP_JR   = 6'b111001;
  localparam logic [5:0] OP_JAL  = 6'b111010;
  localparam logic [5:0] OP_HALT = 6'b111111;

  function automatic logic op_defined(input logic [5:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_ADDI, OP_OR, OP_AND, OP_ORI, OP_SLL, OP_SLT,
      OP_SLTI, OP_SW, OP_LW, OP_BEQ, OP_BNE, OP_BGTZ, OP_J, OP_JR,
      OP_JAL, OP_HALT: return 1'b1;
      default:         return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_next_state.sv
// Pure combinational next-state function of the multi-cycle sequencer.
//
// state | meaning
// ------+--------------------------------------------------------
// IF    | fetch; waits for mem_ready, watchdog may force HALT
// ID    | decode; jumps finish here, halt/undefined go to HALT
// EXE   | execute; branches finish here, sw/lw go to MEM
// MEM   | data access; waits for mem_ready, watchdog may force HALT
// WB    | register write-back, always returns to IF
// HALT  | terminal until reset
// 110/111 are unreachable codes and recover to IF
//
// Ports:
//   state      current registered state
//   opcode     IR[31:26]
//   mem_ready  memory completes the access this cycle
//   timeout    watchdog expired this cycle (already qualified by mem_ready=0)
//   state_nxt  state for the next cycle
module ctrl_next_state
  import cpu_ctrl_pkg::*;
(
  input  state_t     state,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  input  logic       timeout,
  output state_t     state_nxt
);

  always_comb begin
    state_nxt = ST_IF;
    case (state)
      ST_IF: begin
        if (mem_ready)    state_nxt = ST_ID;
        else if (timeout) state_nxt = ST_HALT;
        else              state_nxt = ST_IF;
      end
      ST_ID: begin
        case (opcode)
          OP_J, OP_JAL, OP_JR: state_nxt = ST_IF;
          OP_HALT:             state_nxt = ST_HALT;
          default:             state_nxt = op_defined(opcode) ? ST_EXE : ST_HALT;
        endcase
      end
      ST_EXE: begin
        case (opcode)
          OP_BEQ, OP_BNE, OP_BGTZ: state_nxt = ST_IF;
          OP_SW, OP_LW:            state_nxt = ST_MEM;
          default:                 state_nxt = ST_WB;
        endcase
      end
      ST_MEM: begin
        if (mem_ready)    state_nxt = (opcode == OP_SW) ? ST_IF : ST_WB;
        else if (timeout) state_nxt = ST_HALT;
        else              state_nxt = ST_MEM;
      end
      ST_WB:   state_nxt = ST_IF;
      ST_HALT: state_nxt = ST_HALT;
      default: state_nxt = ST_IF;
    endcase
  end

endmodule

// File: rtl/multi_cycle_sequencer.sv
// Sequencing controller for the multi-cycle CPU datapath.
// Holds the instruction state register, decodes the per-state enables,
// runs the memory wait-state watchdog and keeps cycle/retired counters.
//
// Ports:
//   CLK, RST_n        clock (rising edge), async active-low reset
//   Opcode            IR[31:26], stable from ID onward
//   zero, sign        ALU flags, sampled in EXE
//   mem_ready         memory completes the access this cycle
//   state             current state code
//   PCWre, PCSrc      PC write enable and source select
//   IRWre, RegWre     IR / register-file write enables
//   WrRa              register write targets $31
//   mem_req, mem_we   memory strobe and write qualifier
//   halted, illegal, bus_err   stop status
//   cycle_cnt, instr_cnt       cycles since reset, retired instructions
module multi_cycle_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int CNT_W      = 32,
  parameter int WAIT_LIMIT = 0
) (
  input  logic             CLK,
  input  logic             RST_n,
  input  logic [5:0]       Opcode,
  input  logic             zero,
  input  logic             sign,
  input  logic             mem_ready,
  output logic [2:0]       state,
  output logic             PCWre,
  output logic [1:0]       PCSrc,
  output logic             IRWre,
  output logic             RegWre,
  output logic             WrRa,
  output logic             mem_req,
  output logic             mem_we,
  output logic             halted,
  output logic             illegal,
  output logic             bus_err,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instr_cnt
);

  localparam logic [7:0] WAIT_LIM = 8'(WAIT_LIMIT);

  state_t     state_q;
  state_t     state_nxt;
  logic [7:0] wait_cnt;
  logic       in_wait;
  logic       timeout;
  logic       retire;
  logic       illegal_q;
  logic       bus_err_q;

  logic       pc_wre;
  logic [1:0] pc_src;
  logic       ir_wre;
  logic       reg_wre;
  logic       wr_ra;
  logic       req;
  logic       we;

  assign in_wait = (state_q == ST_IF) || (state_q == ST_MEM);
  // mem_ready in the limit cycle wins over the timeout.
  assign timeout = (WAIT_LIMIT != 0) && in_wait && !mem_ready && (wait_cnt == WAIT_LIM);

  ctrl_next_state u_next_state (
    .state     (state_q),
    .opcode    (Opcode),
    .mem_ready (mem_ready),
    .timeout   (timeout),
    .state_nxt (state_nxt)
  );

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) state_q <= ST_IF;
    else        state_q <= state_nxt;
  end

  // Any state change is an entry into a fresh wait window.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      wait_cnt <= 8'd0;
    end else if (state_nxt != state_q) begin
      wait_cnt <= 8'd0;
    end else if (in_wait && !mem_ready && (wait_cnt != 8'hFF)) begin
      wait_cnt <= wait_cnt + 8'd1;
    end
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      if ((state_q == ST_ID) && !op_defined(Opcode)) illegal_q <= 1'b1;
      if (timeout)                                    bus_err_q <= 1'b1;
    end
  end

  // Completion into IF from a working state, or the halt opcode itself;
  // error halts and IF stalls never count.
  assign retire = ((state_nxt == ST_IF) &&
                   ((state_q == ST_ID) || (state_q == ST_EXE) ||
                    (state_q == ST_MEM) || (state_q == ST_WB))) ||
                  ((state_q == ST_ID) && (Opcode == OP_HALT));

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      cycle_cnt <= '0;
      instr_cnt <= '0;
    end else begin
      if (state_q != ST_HALT) cycle_cnt <= cycle_cnt + CNT_W'(1);
      if (retire)             instr_cnt <= instr_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    pc_wre  = 1'b0;
    pc_src  = 2'b00;
    ir_wre  = 1'b0;
    reg_wre = 1'b0;
    wr_ra   = 1'b0;
    req     = 1'b0;
    we      = 1'b0;
    case (state_q)
      ST_IF: begin
        req = 1'b1;
        if (mem_ready) begin
          ir_wre = 1'b1;
          pc_wre = 1'b1;
        end
      end
      ST_ID: begin
        case (Opcode)
          OP_J: begin
            pc_wre = 1'b1;
            pc_src = 2'b10;
          end
          OP_JAL: begin
            pc_wre  = 1'b1;
            pc_src  = 2'b10;
            reg_wre = 1'b1;
            wr_ra   = 1'b1;
          end
          OP_JR: begin
            pc_wre = 1'b1;
            pc_src = 2'b11;
          end
          default: ;
        endcase
      end
      ST_EXE: begin
        case (Opcode)
          OP_BEQ: begin
            pc_wre = zero;
            pc_src = 2'b01;
          end
          OP_BNE: begin
            pc_wre = ~zero;
            pc_src = 2'b01;
          end
          OP_BGTZ: begin
            pc_wre = ~zero & ~sign;
            pc_src = 2'b01;
          end
          default: ;
        endcase
      end
      ST_MEM: begin
        req = 1'b1;
        we  = (Opcode == OP_SW);
      end
      ST_WB:   reg_wre = 1'b1;
      default: ;
    endcase
  end

  // Strobes are held off combinationally for the whole time reset is low.
  assign state   = state_q;
  assign PCWre   = pc_wre  & RST_n;
  assign PCSrc   = RST_n ? pc_src : 2'b00;
  assign IRWre   = ir_wre  & RST_n;
  assign RegWre  = reg_wre & RST_n;
  assign WrRa    = wr_ra   & RST_n;
  assign mem_req = req     & RST_n;
  assign mem_we  = we      & RST_n;
  assign halted  = (state_q == ST_HALT);
  assign illegal = illegal_q;
  assign bus_err = bus_err_q;

endmodule
